// File: rtl/count_disp_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment display driver.
// Segment patterns are active-low, bit0 = a ... bit6 = g, bit7 = dp (always off).
package count_disp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK0 = 3'd1,
    SHOW0  = 3'd2,
    BLANK1 = 3'd3,
    SHOW1  = 3'd4
  } state_t;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [1:0] AN_OFF = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// Combinational binary digit to active-low seven-segment pattern; values above 9 show "E".
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [6:0] val,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (val)
      7'd0:    seg = SEG_0;
      7'd1:    seg = SEG_1;
      7'd2:    seg = SEG_2;
      7'd3:    seg = SEG_3;
      7'd4:    seg = SEG_4;
      7'd5:    seg = SEG_5;
      7'd6:    seg = SEG_6;
      7'd7:    seg = SEG_7;
      7'd8:    seg = SEG_8;
      7'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/count_disp.sv
// Two-digit time-multiplexed active-low seven-segment scanner with per-frame shadow capture.
// Optional leading-zero blanking of the tens digit: define COUNT_DISP_LZB_EN.
module count_disp
  import count_disp_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rest_n,
  input  logic       en,
  input  logic [6:0] in_ones,
  input  logic [6:0] in_tens,
  output logic [7:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int TW = $clog2(DIV);
  localparam int BL = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int DL = DIV - 1;
  localparam logic [TW-1:0] BLANK_LAST = BL[TW-1:0];
  localparam logic [TW-1:0] DIV_LAST   = DL[TW-1:0];
  localparam state_t FIRST0 = (BLANK == 0) ? SHOW0 : BLANK0;
  localparam state_t FIRST1 = (BLANK == 0) ? SHOW1 : BLANK1;

  state_t        state, nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [6:0]    ones_sh, tens_sh, ones_nxt, tens_nxt;
  logic [7:0]    ones_seg, tens_seg, seg_nxt;
  logic [1:0]    an_nxt;
  logic          cap;

  // The blank/show halves of a slot share one tick run; it only clears between slots.
  always_comb begin
    nxt      = state;
    tick_nxt = tick + TW'(1);
    cap      = 1'b0;
    if (!en) begin
      nxt      = IDLE;
      tick_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt      = FIRST0;
          tick_nxt = '0;
          cap      = 1'b1;
        end
        BLANK0: if (tick == BLANK_LAST) nxt = SHOW0;
        SHOW0: if (tick == DIV_LAST) begin
          nxt      = FIRST1;
          tick_nxt = '0;
        end
        BLANK1: if (tick == BLANK_LAST) nxt = SHOW1;
        SHOW1: if (tick == DIV_LAST) begin
          nxt      = FIRST0;
          tick_nxt = '0;
          cap      = 1'b1;
        end
        default: begin
          nxt      = IDLE;
          tick_nxt = '0;
        end
      endcase
    end
  end

  assign ones_nxt = cap ? in_ones : ones_sh;
  assign tens_nxt = cap ? in_tens : tens_sh;

  seg7_decode u_dec_ones (.val(ones_nxt), .seg(ones_seg));
  seg7_decode u_dec_tens (.val(tens_nxt), .seg(tens_seg));

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    case (nxt)
      SHOW0: begin
        an_nxt  = 2'b10;
        seg_nxt = ones_seg;
      end
      SHOW1: begin
`ifdef COUNT_DISP_LZB_EN
        if (tens_nxt != 7'd0) begin
          an_nxt  = 2'b01;
          seg_nxt = tens_seg;
        end
`else
        an_nxt  = 2'b01;
        seg_nxt = tens_seg;
`endif
      end
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state   <= IDLE;
      tick    <= '0;
      ones_sh <= '0;
      tens_sh <= '0;
      an      <= AN_OFF;
      seg     <= SEG_OFF;
      frame   <= 1'b0;
    end else begin
      state   <= nxt;
      tick    <= tick_nxt;
      ones_sh <= ones_nxt;
      tens_sh <= tens_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
      frame   <= cap;
    end
  end

endmodule

// File: tb/tb_count_disp.sv
// Scoreboard bench for count_disp (DIV=8, BLANK=2): expected {frame, an, seg} per cycle is queued, then compared.
module tb_count_disp;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FLEN  = 2 * DIV;

  logic       clk;
  logic       rest_n;
  logic       en;
  logic [6:0] in_ones;
  logic [6:0] in_tens;
  logic [7:0] seg;
  logic [1:0] an;
  logic       frame;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];

  count_disp #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk     (clk),
    .rest_n  (rest_n),
    .en      (en),
    .in_ones (in_ones),
    .in_tens (in_tens),
    .seg     (seg),
    .an      (an),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got frame/an/seg=%h required=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected outputs for the first n cycles of a frame, straight from the slot timing.
  task automatic push_frame(input logic [7:0] s0, input logic [1:0] an1, input logic [7:0] s1, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < BLANK)            exp_q.push_back({(i == 0), 2'b11, 8'hFF});
      else if (i < DIV)         exp_q.push_back({1'b0, 2'b10, s0});
      else if (i < DIV + BLANK) exp_q.push_back({1'b0, 2'b11, 8'hFF});
      else                      exp_q.push_back({1'b0, an1, s1});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 2'b11, 8'hFF});
  endtask

  task automatic step(input string tag, input int n);
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty at %0t", tag, $time);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {frame, an, seg}, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rest_n  = 1'b0;
    en      = 1'b0;
    in_ones = 7'd0;
    in_tens = 7'd0;
    #12;
    chk("reset_state", {frame, an, seg}, {1'b0, 2'b11, 8'hFF});
    @(negedge clk);
    rest_n = 1'b1;
    push_idle(2);
    step("idle", 2);

    // Basic scan: two back-to-back frames, with a mid-SHOW0 change to ones in the second.
    in_tens = 7'd4;
    in_ones = 7'd7;
    en      = 1'b1;
    push_frame(8'hF8, 2'b01, 8'h99, FLEN);
    step("scan47", FLEN);
    push_frame(8'hF8, 2'b01, 8'h99, FLEN);
    step("scan47_rep", 4);
    in_ones = 7'd5;
    step("tearfree", FLEN - 4);
    push_frame(8'h92, 2'b01, 8'h99, FLEN);
    step("update45", FLEN);

    // Out-of-range digits decode to E.
    in_ones = 7'd12;
    in_tens = 7'd99;
    push_frame(8'h86, 2'b01, 8'h86, FLEN);
    step("oor", FLEN);

    // Leading zero on tens.
    in_ones = 7'd9;
    in_tens = 7'd0;
`ifdef COUNT_DISP_LZB_EN
    push_frame(8'h90, 2'b11, 8'hFF, FLEN);
`else
    push_frame(8'h90, 2'b01, 8'hC0, FLEN);
`endif
    step("lzero", FLEN);

    // Enable drop mid-SHOW1, then restart.
    in_ones = 7'd3;
    in_tens = 7'd8;
    push_frame(8'hB0, 2'b01, 8'h80, 12);
    step("pre_drop", 12);
    en = 1'b0;
    push_idle(3);
    step("en_drop", 3);
    en = 1'b1;
    push_frame(8'hB0, 2'b01, 8'h80, FLEN);
    step("en_restart", FLEN);

    // Asynchronous reset mid-SHOW0.
    in_ones = 7'd1;
    in_tens = 7'd2;
    push_frame(8'hF9, 2'b01, 8'hA4, 5);
    step("pre_reset", 5);
    #2;
    rest_n = 1'b0;
    #1;
    chk("async_reset", {frame, an, seg}, {1'b0, 2'b11, 8'hFF});
    en = 1'b0;
    @(negedge clk);
    rest_n = 1'b1;
    push_idle(2);
    step("post_reset_idle", 2);
    en = 1'b1;
    push_frame(8'hF9, 2'b01, 8'hA4, FLEN);
    step("post_reset_frame", FLEN);

    chk("queue_drained", 11'(exp_q.size()), 11'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
